// File: rtl/lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_text_ctrl
// HD44780-class character-LCD refresh controller. After reset it waits for
// the panel to power up, issues the four-command init sequence, then
// repaints every row continuously (or stops after the current frame when
// refresh_en drops). Every LCD transfer occupies one slot of STEP_MS
// millisecond ticks: row/col update on entering phase 0, bus loads on
// phase 1, E rises on phase 2 and falls on phase 3.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   refresh_en  1 = keep repainting, 0 = stop after the current frame
//   char_row    row of the character currently requested from the source
//   char_col    column of the character currently requested
//   char_data   CGROM code for (char_row, char_col)
//   init_done   level, set once the init sequence completes
//   frame_done  one-clk pulse when the last char of the last row is written
//   lcd_e       LCD enable strobe
//   lcd_rs      0 = command, 1 = data
//   lcd_rw      always 0 (write only)
//   lcd_data    LCD data bus
// ---------------------------------------------------------------------------
module lcd_text_ctrl #(
    parameter int CLK_PER_MS = 100000,
    parameter int STEP_MS    = 4,
    parameter int PWRUP_MS   = 100,
    parameter int ROWS       = 2,
    parameter int COLS       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_en,
    output logic [1:0] char_row,
    output logic [4:0] char_col,
    input  logic [7:0] char_data,
    output logic       init_done,
    output logic       frame_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int MS_W = $clog2(CLK_PER_MS);
    localparam int PH_W = $clog2(STEP_MS);
    localparam int PU_W = (PWRUP_MS > 1) ? $clog2(PWRUP_MS) : 1;

    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(CLK_PER_MS - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(STEP_MS - 1);
    localparam logic [PH_W-1:0] PH_0     = PH_W'(0);
    localparam logic [PH_W-1:0] PH_1     = PH_W'(1);
    localparam logic [PH_W-1:0] PH_2     = PH_W'(2);
    localparam logic [PU_W-1:0] PU_LAST  = PU_W'(PWRUP_MS - 1);
    localparam logic [1:0]      ROW_LAST = 2'(ROWS - 1);
    localparam logic [4:0]      COL_LAST = 5'(COLS - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FUNC_SET,
        S_DISP_ON,
        S_CLEAR,
        S_ENTRY,
        S_ADDR,
        S_CHAR,
        S_IDLE
    } state_t;

    // DDRAM start address of each row on 1/2/4-line panels.
    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(COLS);
            default: row_base = 8'h40 + 8'(COLS);
        endcase
    endfunction

    state_t          r_state;
    logic [MS_W-1:0] r_ms_cnt;
    logic [PH_W-1:0] r_phase;
    logic [PU_W-1:0] r_pwr_cnt;
    logic [1:0]      r_row;
    logic [4:0]      r_col;
    logic            r_init_done;
    logic            r_frame_done;
    logic            r_lcd_e;
    logic            r_lcd_rs;
    logic [7:0]      r_lcd_data;

    logic            w_tick;
    logic            w_bus_rs;
    logic [7:0]      w_bus_byte;

    assign w_tick = (r_ms_cnt == MS_LAST);

    // Free-running millisecond prescaler; first tick lands CLK_PER_MS clks
    // after reset release.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ms_cnt <= '0;
        end else if (w_tick) begin
            r_ms_cnt <= '0;
        end else begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

    // Byte and RS to present when the current slot reaches phase 1.
    // NOTE: both outputs get a default first so no path leaves them unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        w_bus_rs   = 1'b0;
        w_bus_byte = 8'h00;
        case (r_state)
            S_FUNC_SET: w_bus_byte = 8'h38;
            S_DISP_ON:  w_bus_byte = 8'h0C;
            S_CLEAR:    w_bus_byte = 8'h01;
            S_ENTRY:    w_bus_byte = 8'h06;
            S_ADDR:     w_bus_byte = 8'h80 | row_base(r_row);
            S_CHAR: begin
                w_bus_rs   = 1'b1;
                w_bus_byte = char_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_PWRUP;
            r_phase      <= '0;
            r_pwr_cnt    <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_lcd_e      <= 1'b0;
            r_lcd_rs     <= 1'b0;
            r_lcd_data   <= 8'h00;
        end else begin
            r_frame_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_PWRUP: begin
                        if (r_pwr_cnt == PU_LAST) begin
                            r_state <= S_FUNC_SET;
                            r_phase <= '0;
                        end else begin
                            r_pwr_cnt <= r_pwr_cnt + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (refresh_en) begin
                            r_state <= S_ADDR;
                            r_phase <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                        end
                    end
                    default: begin
                        if (r_phase != PH_LAST) begin
                            r_phase <= r_phase + 1'b1;
                            // Action belongs to the phase being entered.
                            case (r_phase)
                                PH_0: begin
                                    r_lcd_rs   <= w_bus_rs;
                                    r_lcd_data <= w_bus_byte;
                                end
                                PH_1:    r_lcd_e <= 1'b1;
                                PH_2:    r_lcd_e <= 1'b0;
                                default: ;
                            endcase
                        end else begin
                            // Slot ends: pick the next slot, phase 0.
                            r_phase <= '0;
                            case (r_state)
                                S_FUNC_SET: r_state <= S_DISP_ON;
                                S_DISP_ON:  r_state <= S_CLEAR;
                                S_CLEAR:    r_state <= S_ENTRY;
                                S_ENTRY: begin
                                    r_init_done <= 1'b1;
                                    r_state     <= S_ADDR;
                                    r_row       <= '0;
                                    r_col       <= '0;
                                end
                                S_ADDR: begin
                                    r_state <= S_CHAR;
                                    r_col   <= '0;
                                end
                                S_CHAR: begin
                                    if (r_col != COL_LAST) begin
                                        r_col <= r_col + 5'd1;
                                    end else if (r_row != ROW_LAST) begin
                                        r_state <= S_ADDR;
                                        r_row   <= r_row + 2'd1;
                                        r_col   <= '0;
                                    end else begin
                                        // Frame complete; refresh_en only
                                        // matters here, never mid-frame.
                                        r_frame_done <= 1'b1;
                                        if (refresh_en) begin
                                            r_state <= S_ADDR;
                                            r_row   <= '0;
                                            r_col   <= '0;
                                        end else begin
                                            r_state <= S_IDLE;
                                        end
                                    end
                                end
                                default: r_state <= S_PWRUP;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign char_row   = r_row;
    assign char_col   = r_col;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;
    assign lcd_e      = r_lcd_e;
    assign lcd_rs     = r_lcd_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = r_lcd_data;

endmodule
